// File: rtl/trdb_pkg.sv
// Shared trace-decoder types and constants.
// No logic; latency n/a.
// No flow control; pure declarations.
package trdb_pkg;

    // Counting-unit selection shared by the resync blocks
    localparam logic CYCLE_MODE  = 1'b0;
    localparam logic PACKET_MODE = 1'b1;

    // E-Trace format / subformat codes relevant to synchronisation
    localparam logic [1:0] F_SYNC   = 2'b11;
    localparam logic [1:0] SF_START = 2'b00;
    localparam logic [1:0] SF_TRAP  = 2'b01;

    typedef enum logic [1:0] {
        UNSYNCED = 2'b00,
        SYNCED   = 2'b01,
        LOST     = 2'b10
    } trdb_sync_state_e;

    // Only start and trap subformats re-anchor the decoder; context and
    // support packets share the format code but carry no sync point.
    function automatic logic is_sync_pkt(input logic       vld,
                                         input logic [1:0] fmt,
                                         input logic [1:0] subfmt);
        return vld && (fmt == F_SYNC) && ((subfmt == SF_START) || (subfmt == SF_TRAP));
    endfunction

endpackage

// File: rtl/trdb_resync_checker.sv
// Watches decoded trace packets and flags sync-to-sync intervals beyond MAX_VALUE+SLACK.
// Latency: one cycle from triggering input to every (registered) output.
// No backpressure: observes the packet stream passively, never stalls it.
module trdb_resync_checker
    import trdb_pkg::*;
#(
    parameter logic        MODE      = CYCLE_MODE,
    parameter int unsigned MAX_VALUE = 16'hFFFF,
    parameter int unsigned SLACK     = 8,
    parameter int unsigned ERR_W     = 8,
    localparam int unsigned LIMIT    = MAX_VALUE + SLACK,
    localparam int unsigned CNT_W    = $clog2(LIMIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             packet_valid_i,
    input  logic [1:0]       packet_format_i,
    input  logic [1:0]       packet_subformat_i,
    input  logic             clear_i,
    output logic             synced_o,
    output logic             resync_late_o,
    output logic             resync_err_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [CNT_W-1:0] interval_o
);

    // Last counter value before the interval becomes late
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

    trdb_sync_state_e state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic             synced_q;
    logic             late_q;
    logic             err_q;
    logic [ERR_W-1:0] err_count_q;

    logic sync_pkt;
    logic incr;
    logic late_evt;

    assign sync_pkt = is_sync_pkt(packet_valid_i, packet_format_i, packet_subformat_i);
    assign incr     = enable_i && ((MODE == CYCLE_MODE) || packet_valid_i);

    // Next-state, counter and interval decode; disable overrides everything
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        interval_d = interval_q;
        late_evt   = 1'b0;
        if (!enable_i) begin
            state_d   = UNSYNCED;
            counter_d = '0;
        end else begin
            case (state_q)
                UNSYNCED: begin
                    counter_d = '0;
                    if (sync_pkt) begin
                        state_d = SYNCED;
                    end
                end
                SYNCED: begin
                    if (sync_pkt) begin
                        // Sync beats a coincident limit crossing
                        interval_d = counter_q + CNT_W'(1);
                        counter_d  = '0;
                    end else if (incr && (counter_q == LIMIT_M1)) begin
                        // Counter freezes at LIMIT-1 until the next sync
                        state_d  = LOST;
                        late_evt = 1'b1;
                    end else if (incr) begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                LOST: begin
                    // No valid interval to report when re-acquiring from LOST
                    if (sync_pkt) begin
                        state_d   = SYNCED;
                        counter_d = '0;
                    end
                end
                default: begin
                    state_d   = UNSYNCED;
                    counter_d = '0;
                end
            endcase
        end
    end

    // FSM, interval counter and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= UNSYNCED;
            counter_q  <= '0;
            interval_q <= '0;
            synced_q   <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            interval_q <= interval_d;
            synced_q   <= (state_d == SYNCED);
            late_q     <= late_evt;
        end
    end

    // Sticky flag and saturating late-event counter; a late event beats clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else if (late_evt) begin
            err_q <= 1'b1;
            if (clear_i) begin
                err_count_q <= ERR_W'(1);
            end else if (err_count_q != {ERR_W{1'b1}}) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end else if (clear_i) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end
    end

    assign synced_o      = synced_q;
    assign resync_late_o = late_q;
    assign resync_err_o  = err_q;
    assign err_count_o   = err_count_q;
    assign interval_o    = interval_q;

endmodule
